mnist_load_ctrl: RTL and testbench
==================================

# mnist_load_ctrl

Sequencer that replaces hand-driven load/compute control of `mnist_nn`. It accepts a 1-bit serial stream of weights and input pixels over a valid/ready handshake. It writes the stream into the weight banks W1..W4 and then the input bank through the `*_oc` load ports, then switches `mnist_nn` to compute mode. It holds `en_compute` until `compute_finish` and returns to load mode.

## Interface
Parameters:
- W_ADDR_LEN, 20, weight address width
- X_ADDR_LEN, 10, input address width
- W_SEL_LEN, 2, weight bank select width
- X_SEL_LEN, 2, input bank select width
- W1_DEPTH / W2_DEPTH / W3_DEPTH / W4_DEPTH, 6 / 9 / 9 / 9, words per weight bank (each ≥1, < 2^W_ADDR_LEN)
- X_DEPTH, 2, input words (≥1, < 2^X_ADDR_LEN)
- TIMEOUT_CYCLES, 1000000, compute watchdog limit (used only with macro)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset; asynchronous, active-high
- start  in  1  begin a load+compute run; sampled in IDLE only
- s_valid  in  1  stream word valid
- s_data  in  1  stream word; order is W1, W2, W3, W4, X, each bank from address 0 upward
- s_ready  out  1  word accepted on an edge where s_valid && s_ready
- w_wq_oc  out  1  weight write enable
- w_addr_oc  out  W_ADDR_LEN  weight address
- w_sel_oc  out  W_SEL_LEN  weight bank (0..3 = W1..W4)
- x_wq_oc  out  1  input write enable
- x_addr_oc  out  X_ADDR_LEN  input address
- x_sel_oc  out  X_SEL_LEN  input bank (always 0)
- wx_write_oc  out  1  write data, shared by weight and input banks
- load_compute_ctrl  out  1  1 = load mode, 0 = compute mode
- en_compute  out  1  compute enable
- compute_finish  in  1  from `mnist_nn`
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse on successful completion
- timeout_err  out  1  sticky watchdog flag (tied 0 without macro)

## Operation
- States: IDLE, LOAD_W, LOAD_X, HANDOFF, COMPUTE.
- IDLE:
  - start=1 → LOAD_W with seg=0 and cnt=0.
  - start is ignored in every other state.
- LOAD_W:
  - s_ready=1.
  - Each accepted word writes bank seg at address cnt.
  - When cnt==DEPTH(seg)−1: cnt←0 and seg←seg+1.
  - After seg 3 finishes → LOAD_X.
- LOAD_X:
  - s_ready=1.
  - Each accepted word is written to address cnt.
  - After the word with cnt==X_DEPTH−1 → HANDOFF.
- HANDOFF:
  - Lasts one cycle; load_compute_ctrl←0.
  - Then → COMPUTE with en_compute←1.
- COMPUTE:
  - en_compute stays 1 until compute_finish is sampled 1.
  - Then: en_compute←0, load_compute_ctrl←1, done←1 for one cycle, → IDLE.
- s_ready=0 outside LOAD_W and LOAD_X. s_ready is decoded from the registered state only and never depends on s_valid.
- compute_finish is ignored outside COMPUTE.
- cnt width is max(W_ADDR_LEN, X_ADDR_LEN). cnt never wraps, because the depth compare ends each segment.
- Reset values:
  - load_compute_ctrl=1.
  - All other outputs 0; state IDLE; seg=0; cnt=0.
- Reset mid-run: everything returns to reset values immediately. A partial load is abandoned, and memory contents are left as-is.

## Timing
- All outputs except s_ready and busy are registered.
- Word accepted at edge k → write enable, address, select and data are valid for exactly the cycle (k, k+1). The write enable drops at k+1 unless another word is accepted at k+1.
- Back-to-back acceptance sustains one write per cycle. s_valid gaps insert idle cycles with the write enable low.
- Last X word accepted at edge k:
  - x_wq_oc=1 during (k, k+1).
  - load_compute_ctrl=0 from k+1.
  - en_compute=1 from k+2.
- compute_finish=1 sampled at edge m → en_compute=0, load_compute_ctrl=1, done=1 during (m, m+1). busy=0 from m.
- start→s_ready latency: start sampled at edge j → s_ready=1 from j.
- Address and select outputs hold their last values when the write enable is low.

## Configuration
- Macro: MNIST_LOAD_CTRL_TIMEOUT_EN.
- Defined:
  - A counter runs in COMPUTE.
  - If TIMEOUT_CYCLES cycles elapse without compute_finish: en_compute←0, load_compute_ctrl←1, timeout_err←1, → IDLE, and no done pulse.
  - timeout_err clears on the next accepted start or on reset.
- Undefined: no counter; COMPUTE waits indefinitely; timeout_err tied 0.

## Structure
- Shared package `mnist_nn_pkg`:
  - state enum;
  - bank select constants SEL_W1..SEL_W4 = 0..3 and SEL_X0 = 0;
  - default depth constants.
- One natural sub-module, `mnist_load_addr_gen`: holds seg and cnt, compares against the per-segment depth, and outputs seg_last and load_last. The FSM, output registers and watchdog stay in the top module.

## Test plan
- Default depths, s_valid held 1, stream of 35 words of alternating 1/0 → exactly 35 write pulses. W1 addresses 0..5 with sel 0; W2–W4 addresses 0..8 with sel 1..3; X addresses 0..1. load_compute_ctrl falls 1 cycle after the last write; en_compute rises 1 cycle after that.
- Random s_valid gaps (~50%) → same write sequence and data; write enable low in every gap cycle.
- compute_finish asserted 20 cycles after en_compute → en_compute low, load_compute_ctrl high and done high for 1 cycle on the same edge. start pulsed during the run has no effect.
- rst asserted mid-W3 (asynchronously, between edges) → all outputs at reset values before the next edge. A new start reloads from W1 address 0.
- MNIST_LOAD_CTRL_TIMEOUT_EN with TIMEOUT_CYCLES=16 and compute_finish never asserted → after 16 COMPUTE cycles: timeout_err=1, en_compute=0, done never pulses. The next start clears timeout_err.

Source files
------------

// File: rtl/mnist_nn_pkg.sv
// mnist_nn_pkg
// Shared definitions for the mnist_nn load/compute sequencer.
//   state_t          : sequencer FSM states
//   SEL_W1..SEL_W4   : weight bank select codes (W1..W4)
//   SEL_X0           : input bank select code
//   SEG_*            : internal load segment codes (four weight banks, then input)
//   DEF_*_DEPTH      : default words per bank
//   max_int()        : elaboration-time helper for width sizing
package mnist_nn_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_W,
        ST_LOAD_X,
        ST_HANDOFF,
        ST_COMPUTE
    } state_t;

    localparam int unsigned SEL_W1 = 0;
    localparam int unsigned SEL_W2 = 1;
    localparam int unsigned SEL_W3 = 2;
    localparam int unsigned SEL_W4 = 3;
    localparam int unsigned SEL_X0 = 0;

    // Segment codes: low two bits of a weight segment equal its bank select.
    localparam logic [2:0] SEG_W1 = 3'd0;
    localparam logic [2:0] SEG_W2 = 3'd1;
    localparam logic [2:0] SEG_W3 = 3'd2;
    localparam logic [2:0] SEG_W4 = 3'd3;
    localparam logic [2:0] SEG_X  = 3'd4;

    localparam int DEF_W1_DEPTH = 6;
    localparam int DEF_W2_DEPTH = 9;
    localparam int DEF_W3_DEPTH = 9;
    localparam int DEF_W4_DEPTH = 9;
    localparam int DEF_X_DEPTH  = 2;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/mnist_load_addr_gen.sv
// mnist_load_addr_gen
// Segment/word counter for the serial load stream. Walks W1..W4 and then the
// input bank, each from address 0 up to its depth minus one.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   clear      : restart at W1 address 0 (new run accepted)
//   advance    : one stream word accepted this cycle
//   seg_last   : current word is the last of its segment
//   load_last  : current word is the last word of the whole load
//   sel        : bank select of the current weight segment
//   w_addr     : current address, weight-bank width
//   x_addr     : current address, input-bank width
module mnist_load_addr_gen
    import mnist_nn_pkg::*;
#(
    parameter int W_ADDR_LEN = 20,
    parameter int X_ADDR_LEN = 10,
    parameter int W_SEL_LEN  = 2,
    parameter int W1_DEPTH   = DEF_W1_DEPTH,
    parameter int W2_DEPTH   = DEF_W2_DEPTH,
    parameter int W3_DEPTH   = DEF_W3_DEPTH,
    parameter int W4_DEPTH   = DEF_W4_DEPTH,
    parameter int X_DEPTH    = DEF_X_DEPTH,
    parameter int CNT_LEN    = max_int(W_ADDR_LEN, X_ADDR_LEN)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  advance,
    output logic                  seg_last,
    output logic                  load_last,
    output logic [W_SEL_LEN-1:0]  sel,
    output logic [W_ADDR_LEN-1:0] w_addr,
    output logic [X_ADDR_LEN-1:0] x_addr
);

    logic [2:0]         seg_reg;
    logic [CNT_LEN-1:0] cnt_reg;
    logic [CNT_LEN-1:0] cnt_last;

    always_comb begin
        cnt_last = CNT_LEN'(W1_DEPTH - 1);
        case (seg_reg)
            SEG_W2:  cnt_last = CNT_LEN'(W2_DEPTH - 1);
            SEG_W3:  cnt_last = CNT_LEN'(W3_DEPTH - 1);
            SEG_W4:  cnt_last = CNT_LEN'(W4_DEPTH - 1);
            SEG_X:   cnt_last = CNT_LEN'(X_DEPTH - 1);
            default: cnt_last = CNT_LEN'(W1_DEPTH - 1);
        endcase
    end

    assign seg_last  = (cnt_reg == cnt_last);
    assign load_last = seg_last && (seg_reg == SEG_X);
    assign sel       = W_SEL_LEN'(seg_reg[1:0]);
    assign w_addr    = W_ADDR_LEN'(cnt_reg);
    assign x_addr    = X_ADDR_LEN'(cnt_reg);

    // The depth compare closes every segment, so cnt never wraps on its own.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_reg <= SEG_W1;
            cnt_reg <= '0;
        end else if (clear) begin
            seg_reg <= SEG_W1;
            cnt_reg <= '0;
        end else if (advance) begin
            if (load_last) begin
                seg_reg <= SEG_W1;
                cnt_reg <= '0;
            end else if (seg_last) begin
                seg_reg <= seg_reg + 3'd1;
                cnt_reg <= '0;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mnist_load_ctrl.sv
// mnist_load_ctrl
// Sequencer for mnist_nn: takes a 1-bit serial stream (valid/ready) of weights
// W1..W4 followed by input pixels, writes them through the *_oc load ports,
// then switches mnist_nn to compute mode and waits for compute_finish.
// Optional feature macro: MNIST_LOAD_CTRL_TIMEOUT_EN (compute watchdog of
// TIMEOUT_CYCLES cycles; timeout_err tied 0 when undefined).
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   start                    : begin a run (sampled in IDLE only)
//   s_valid, s_data, s_ready : serial stream handshake
//   w_wq_oc/w_addr_oc/w_sel_oc            : weight bank write port
//   x_wq_oc/x_addr_oc/x_sel_oc            : input bank write port
//   wx_write_oc              : shared write data
//   load_compute_ctrl        : 1 = load mode, 0 = compute mode
//   en_compute, compute_finish : compute handshake with mnist_nn
//   busy, done, timeout_err  : status
module mnist_load_ctrl
    import mnist_nn_pkg::*;
#(
    parameter int W_ADDR_LEN     = 20,
    parameter int X_ADDR_LEN     = 10,
    parameter int W_SEL_LEN      = 2,
    parameter int X_SEL_LEN      = 2,
    parameter int W1_DEPTH       = DEF_W1_DEPTH,
    parameter int W2_DEPTH       = DEF_W2_DEPTH,
    parameter int W3_DEPTH       = DEF_W3_DEPTH,
    parameter int W4_DEPTH       = DEF_W4_DEPTH,
    parameter int X_DEPTH        = DEF_X_DEPTH,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  s_valid,
    input  logic                  s_data,
    output logic                  s_ready,
    output logic                  w_wq_oc,
    output logic [W_ADDR_LEN-1:0] w_addr_oc,
    output logic [W_SEL_LEN-1:0]  w_sel_oc,
    output logic                  x_wq_oc,
    output logic [X_ADDR_LEN-1:0] x_addr_oc,
    output logic [X_SEL_LEN-1:0]  x_sel_oc,
    output logic                  wx_write_oc,
    output logic                  load_compute_ctrl,
    output logic                  en_compute,
    input  logic                  compute_finish,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout_err
);

    state_t state_reg, state_next;

    logic                  w_wq_reg, w_wq_next;
    logic [W_ADDR_LEN-1:0] w_addr_reg, w_addr_next;
    logic [W_SEL_LEN-1:0]  w_sel_reg, w_sel_next;
    logic                  x_wq_reg, x_wq_next;
    logic [X_ADDR_LEN-1:0] x_addr_reg, x_addr_next;
    logic [X_SEL_LEN-1:0]  x_sel_reg, x_sel_next;
    logic                  wx_write_reg, wx_write_next;
    logic                  lcc_reg, lcc_next;
    logic                  en_reg, en_next;
    logic                  done_reg, done_next;

    logic                  accept;
    logic                  start_go;
    logic                  wd_expire;
    logic                  seg_last;
    logic                  load_last;
    logic [W_SEL_LEN-1:0]  gen_sel;
    logic [W_ADDR_LEN-1:0] gen_w_addr;
    logic [X_ADDR_LEN-1:0] gen_x_addr;

    // s_ready comes from the registered state only, never from s_valid.
    assign s_ready  = (state_reg == ST_LOAD_W) || (state_reg == ST_LOAD_X);
    assign busy     = (state_reg != ST_IDLE);
    assign accept   = s_valid && s_ready;
    assign start_go = (state_reg == ST_IDLE) && start;

    mnist_load_addr_gen #(
        .W_ADDR_LEN (W_ADDR_LEN),
        .X_ADDR_LEN (X_ADDR_LEN),
        .W_SEL_LEN  (W_SEL_LEN),
        .W1_DEPTH   (W1_DEPTH),
        .W2_DEPTH   (W2_DEPTH),
        .W3_DEPTH   (W3_DEPTH),
        .W4_DEPTH   (W4_DEPTH),
        .X_DEPTH    (X_DEPTH)
    ) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .clear     (start_go),
        .advance   (accept),
        .seg_last  (seg_last),
        .load_last (load_last),
        .sel       (gen_sel),
        .w_addr    (gen_w_addr),
        .x_addr    (gen_x_addr)
    );

    always_comb begin
        state_next    = state_reg;
        w_wq_next     = 1'b0;
        w_addr_next   = w_addr_reg;
        w_sel_next    = w_sel_reg;
        x_wq_next     = 1'b0;
        x_addr_next   = x_addr_reg;
        x_sel_next    = x_sel_reg;
        wx_write_next = wx_write_reg;
        lcc_next      = lcc_reg;
        en_next       = 1'b0;
        done_next     = 1'b0;

        if (accept) begin
            wx_write_next = s_data;
        end

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_LOAD_W;
                end
            end
            ST_LOAD_W: begin
                if (accept) begin
                    w_wq_next   = 1'b1;
                    w_addr_next = gen_w_addr;
                    w_sel_next  = gen_sel;
                    if (seg_last && (gen_sel == W_SEL_LEN'(SEL_W4))) begin
                        state_next = ST_LOAD_X;
                    end
                end
            end
            ST_LOAD_X: begin
                if (accept) begin
                    x_wq_next   = 1'b1;
                    x_addr_next = gen_x_addr;
                    x_sel_next  = X_SEL_LEN'(SEL_X0);
                    if (load_last) begin
                        state_next = ST_HANDOFF;
                    end
                end
            end
            ST_HANDOFF: begin
                // Compute mode is selected one cycle before en_compute rises.
                lcc_next   = 1'b0;
                state_next = ST_COMPUTE;
            end
            ST_COMPUTE: begin
                // A finish on the same edge as a watchdog expiry counts as success.
                if (compute_finish) begin
                    lcc_next   = 1'b1;
                    done_next  = 1'b1;
                    state_next = ST_IDLE;
                end else if (wd_expire) begin
                    lcc_next   = 1'b1;
                    state_next = ST_IDLE;
                end else begin
                    en_next = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            w_wq_reg     <= 1'b0;
            w_addr_reg   <= '0;
            w_sel_reg    <= '0;
            x_wq_reg     <= 1'b0;
            x_addr_reg   <= '0;
            x_sel_reg    <= '0;
            wx_write_reg <= 1'b0;
            lcc_reg      <= 1'b1;
            en_reg       <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            w_wq_reg     <= w_wq_next;
            w_addr_reg   <= w_addr_next;
            w_sel_reg    <= w_sel_next;
            x_wq_reg     <= x_wq_next;
            x_addr_reg   <= x_addr_next;
            x_sel_reg    <= x_sel_next;
            wx_write_reg <= wx_write_next;
            lcc_reg      <= lcc_next;
            en_reg       <= en_next;
            done_reg     <= done_next;
        end
    end

    assign w_wq_oc           = w_wq_reg;
    assign w_addr_oc         = w_addr_reg;
    assign w_sel_oc          = w_sel_reg;
    assign x_wq_oc           = x_wq_reg;
    assign x_addr_oc         = x_addr_reg;
    assign x_sel_oc          = x_sel_reg;
    assign wx_write_oc       = wx_write_reg;
    assign load_compute_ctrl = lcc_reg;
    assign en_compute        = en_reg;
    assign done              = done_reg;

`ifdef MNIST_LOAD_CTRL_TIMEOUT_EN
    localparam int WD_LEN = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_LEN-1:0] wd_cnt_reg;
    logic              timeout_err_reg;

    // COMPUTE lasts exactly TIMEOUT_CYCLES cycles when no finish arrives.
    assign wd_expire = (state_reg == ST_COMPUTE) && !compute_finish &&
                       (wd_cnt_reg == WD_LEN'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt_reg      <= '0;
            timeout_err_reg <= 1'b0;
        end else begin
            if (state_reg != ST_COMPUTE) begin
                wd_cnt_reg <= '0;
            end else begin
                wd_cnt_reg <= wd_cnt_reg + 1'b1;
            end
            if (start_go) begin
                timeout_err_reg <= 1'b0;
            end else if (wd_expire) begin
                timeout_err_reg <= 1'b1;
            end
        end
    end

    assign timeout_err = timeout_err_reg;
`else
    assign wd_expire   = 1'b0;
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_mnist_load_ctrl.sv
// Self-checking bench for mnist_load_ctrl. The expected write sequence is a
// table built from the bank order/depths; stream data and s_valid gaps are
// randomized, and multi-cycle corners (handoff, finish, reset, watchdog) are
// hand-written sequences.
module tb_mnist_load_ctrl;

    localparam int W_ADDR_LEN = 20;
    localparam int X_ADDR_LEN = 10;
    localparam int W_SEL_LEN  = 2;
    localparam int X_SEL_LEN  = 2;
    localparam int N_WORDS    = 6 + 9 + 9 + 9 + 2;
    localparam int WD_LIMIT   = 16;
`ifdef MNIST_LOAD_CTRL_TIMEOUT_EN
    localparam int FIN_DELAY  = 10;
`else
    localparam int FIN_DELAY  = 20;
`endif

    logic                  clk;
    logic                  rst;
    logic                  start;
    logic                  s_valid;
    logic                  s_data;
    logic                  s_ready;
    logic                  w_wq_oc;
    logic [W_ADDR_LEN-1:0] w_addr_oc;
    logic [W_SEL_LEN-1:0]  w_sel_oc;
    logic                  x_wq_oc;
    logic [X_ADDR_LEN-1:0] x_addr_oc;
    logic [X_SEL_LEN-1:0]  x_sel_oc;
    logic                  wx_write_oc;
    logic                  load_compute_ctrl;
    logic                  en_compute;
    logic                  compute_finish;
    logic                  busy;
    logic                  done;
    logic                  timeout_err;

    mnist_load_ctrl #(
        .W_ADDR_LEN     (W_ADDR_LEN),
        .X_ADDR_LEN     (X_ADDR_LEN),
        .W_SEL_LEN      (W_SEL_LEN),
        .X_SEL_LEN      (X_SEL_LEN),
        .W1_DEPTH       (6),
        .W2_DEPTH       (9),
        .W3_DEPTH       (9),
        .W4_DEPTH       (9),
        .X_DEPTH        (2),
        .TIMEOUT_CYCLES (WD_LIMIT)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .s_valid           (s_valid),
        .s_data            (s_data),
        .s_ready           (s_ready),
        .w_wq_oc           (w_wq_oc),
        .w_addr_oc         (w_addr_oc),
        .w_sel_oc          (w_sel_oc),
        .x_wq_oc           (x_wq_oc),
        .x_addr_oc         (x_addr_oc),
        .x_sel_oc          (x_sel_oc),
        .wx_write_oc       (wx_write_oc),
        .load_compute_ctrl (load_compute_ctrl),
        .en_compute        (en_compute),
        .compute_finish    (compute_finish),
        .busy              (busy),
        .done              (done),
        .timeout_err       (timeout_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One record per stream word: input bit plus the write it must produce.
    typedef struct {
        bit data;
        bit is_w;
        int sel;
        int addr;
    } vec_t;

    vec_t tbl[N_WORDS];
    int   n_checks;
    int   n_fail;

    function automatic int bank_depth(input int b);
        case (b)
            0:       return 6;
            1:       return 9;
            2:       return 9;
            3:       return 9;
            default: return 2;
        endcase
    endfunction

    function automatic void build_table(input bit alt);
        int i;
        i = 0;
        for (int b = 0; b < 5; b++) begin
            for (int a = 0; a < bank_depth(b); a++) begin
                tbl[i].data = alt ? ((i % 2) == 0) : 1'($urandom_range(1));
                tbl[i].is_w = (b < 4);
                tbl[i].sel  = (b < 4) ? b : 0;
                tbl[i].addr = a;
                i++;
            end
        end
    endfunction

    function automatic longint pack_wr(input longint w, input longint x, input longint sel,
                                       input longint addr, input longint d);
        return (w << 24) | (x << 23) | (sel << 21) | (addr << 1) | d;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_s_ready"}, s_ready, 0);
        chk({tag, "_w_wq"}, w_wq_oc, 0);
        chk({tag, "_w_addr"}, w_addr_oc, 0);
        chk({tag, "_w_sel"}, w_sel_oc, 0);
        chk({tag, "_x_wq"}, x_wq_oc, 0);
        chk({tag, "_x_addr"}, x_addr_oc, 0);
        chk({tag, "_x_sel"}, x_sel_oc, 0);
        chk({tag, "_wx_write"}, wx_write_oc, 0);
        chk({tag, "_lcc"}, load_compute_ctrl, 1);
        chk({tag, "_en"}, en_compute, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_timeout_err"}, timeout_err, 0);
    endtask

    // Streams n_words of the table (with gap_pct % empty cycles) and checks
    // every write. A full load also checks the handoff into compute mode.
    task automatic load_run(input int gap_pct, input bit alt, input int n_words);
        int    idx;
        int    cyc;
        bit    v;
        longint act;
        longint exp;
        build_table(alt);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_s_ready", s_ready, 1);
        chk("start_busy", busy, 1);
        chk("start_timeout_err", timeout_err, 0);
        idx = 0;
        cyc = 0;
        while (idx < n_words && cyc < 2000) begin
            v = (gap_pct == 0) || ($urandom_range(99) >= gap_pct);
            chk("s_ready_load", s_ready, 1);
            s_valid        = v;
            s_data         = v ? tbl[idx].data : 1'($urandom_range(1));
            compute_finish = (gap_pct != 0) ? 1'($urandom_range(1)) : 1'b0;
            @(negedge clk);
            cyc++;
            if (v) begin
                exp = pack_wr(tbl[idx].is_w, !tbl[idx].is_w, tbl[idx].sel,
                              tbl[idx].addr, tbl[idx].data);
                if (tbl[idx].is_w)
                    act = pack_wr(w_wq_oc, x_wq_oc, w_sel_oc, w_addr_oc, wx_write_oc);
                else
                    act = pack_wr(w_wq_oc, x_wq_oc, x_sel_oc, x_addr_oc, wx_write_oc);
                chk($sformatf("write[%0d]", idx), act, exp);
                $display("word %0d: w_wq=%0b x_wq=%0b sel=%0d addr=%0d data=%0b", idx,
                         w_wq_oc, x_wq_oc, tbl[idx].is_w ? w_sel_oc : x_sel_oc,
                         tbl[idx].is_w ? w_addr_oc : longint'(x_addr_oc), wx_write_oc);
                idx++;
            end else begin
                chk("gap_wq", {w_wq_oc, x_wq_oc}, 0);
            end
        end
        s_valid        = 1'b0;
        s_data         = 1'b0;
        compute_finish = 1'b0;
        if (idx != n_words) chk("load_cycle_budget", idx, n_words);
        if (n_words == N_WORDS) begin
            chk("lcc_at_last_write", load_compute_ctrl, 1);
            chk("en_at_last_write", en_compute, 0);
            @(negedge clk);
            chk("lcc_handoff", load_compute_ctrl, 0);
            chk("en_handoff", en_compute, 0);
            chk("wq_after_load", {w_wq_oc, x_wq_oc}, 0);
            chk("s_ready_handoff", s_ready, 0);
            @(negedge clk);
            chk("en_rise", en_compute, 1);
            chk("lcc_compute", load_compute_ctrl, 0);
        end
    endtask

    // Holds compute for FIN_DELAY cycles (with a stray start), then finishes.
    task automatic finish_run();
        for (int i = 0; i < FIN_DELAY; i++) begin
            start = (i == 5);
            @(negedge clk);
            chk("en_hold", en_compute, 1);
            chk("done_hold", done, 0);
            chk("s_ready_compute", s_ready, 0);
        end
        start          = 1'b0;
        compute_finish = 1'b1;
        @(negedge clk);
        compute_finish = 1'b0;
        chk("finish_en", en_compute, 0);
        chk("finish_lcc", load_compute_ctrl, 1);
        chk("finish_done", done, 1);
        chk("finish_busy", busy, 0);
        $display("finish: en=%0b lcc=%0b done=%0b busy=%0b", en_compute, load_compute_ctrl,
                 done, busy);
        @(negedge clk);
        chk("done_pulse_end", done, 0);
        chk("idle_s_ready", s_ready, 0);
        chk("idle_busy", busy, 0);
        chk("idle_timeout_err", timeout_err, 0);
    endtask

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        rst            = 1'b1;
        start          = 1'b0;
        s_valid        = 1'b0;
        s_data         = 1'b0;
        compute_finish = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("rst_hold");
        rst = 1'b0;
        @(negedge clk);
        check_reset_vals("post_rst");

        // Back-to-back alternating stream.
        load_run(0, 1'b1, N_WORDS);
        finish_run();

        // Random gaps and random data.
        load_run(50, 1'b0, N_WORDS);
        finish_run();

        // Asynchronous reset in the middle of W3 (word 17 = W3 address 2).
        load_run(0, 1'b0, 6 + 9 + 3);
        #2 rst = 1'b1;
        #1;
        check_reset_vals("async_rst");
        @(negedge clk);
        rst = 1'b0;
        load_run(30, 1'b0, N_WORDS);
        finish_run();

`ifdef MNIST_LOAD_CTRL_TIMEOUT_EN
        begin
            int en_cycles;
            int guard;
            load_run(0, 1'b0, N_WORDS);
            en_cycles = 1;
            guard     = 0;
            while (en_compute && guard < 100) begin
                @(negedge clk);
                guard++;
                chk("wd_no_done", done, 0);
                if (en_compute) en_cycles++;
            end
            chk("wd_en_cycles", en_cycles, WD_LIMIT - 1);
            chk("wd_timeout_err", timeout_err, 1);
            chk("wd_lcc", load_compute_ctrl, 1);
            chk("wd_busy", busy, 0);
            $display("watchdog: en_cycles=%0d timeout_err=%0b", en_cycles, timeout_err);
            repeat (3) begin
                @(negedge clk);
                chk("wd_sticky", timeout_err, 1);
                chk("wd_idle_done", done, 0);
            end
            load_run(0, 1'b0, N_WORDS);
            finish_run();
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
